// File: rtl/bpu_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
// Entry-type encoding, PC slicing and counter constants.
package bpu_pkg;

    typedef enum logic [1:0] {
        COND = 2'd0,
        JAL  = 2'd1,
        JALR = 2'd2,
        RET  = 2'd3
    } btb_type_t;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_JAL  = 2'b01;
    localparam logic [1:0] JUMP_JALR = 2'b10;

    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;

    function automatic logic [63:0] bpu_index(
        input logic [63:0] pc,
        input int          idx_bits
    );
        return (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] bpu_tag(
        input logic [63:0] pc,
        input int          idx_bits,
        input int          tag_bits
    );
        return (pc >> (idx_bits + 2)) & ((64'd1 << tag_bits) - 64'd1);
    endfunction

    // weakly not-taken after reset, weakly taken on allocation
    function automatic int ctr_init(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int ctr_alloc(input int bits);
        return 1 << (bits - 1);
    endfunction

    function automatic int ctr_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    function automatic logic is_link(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// IF-lookup / EX-resolve bundle between the pipeline and the predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_btb_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_F;
    logic [XLEN-1:0] pc4_F;
    logic            taken_F;
    logic [XLEN-1:0] pred_target_F;
    logic [XLEN-1:0] pc_next;

    logic            valid_E;
    logic            branch_E;
    logic [1:0]      jump_E;
    logic [4:0]      rd_E;
    logic [4:0]      rs1_E;
    logic            cond_E;
    logic            taken_E;
    logic [XLEN-1:0] pred_target_E;
    logic [XLEN-1:0] pc_E;
    logic [XLEN-1:0] pc4_E;
    logic [XLEN-1:0] pc_target_E;

    logic            flush;
    logic [XLEN-1:0] pc_restore;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispred;

    modport slave (
        input  pc_F, pc4_F,
        input  valid_E, branch_E, jump_E, rd_E, rs1_E, cond_E,
        input  taken_E, pred_target_E, pc_E, pc4_E, pc_target_E,
        output taken_F, pred_target_F, pc_next,
        output flush, pc_restore, stat_branches, stat_mispred
    );

    modport master (
        output pc_F, pc4_F,
        output valid_E, branch_E, jump_E, rd_E, rs1_E, cond_E,
        output taken_E, pred_target_E, pc_E, pc4_E, pc_target_E,
        input  taken_F, pred_target_F, pc_next,
        input  flush, pc_restore, stat_branches, stat_mispred
    );

endinterface

// File: rtl/bpu_ras.sv
// Circular return-address stack; on overflow the oldest entry is lost,
// popping an empty stack leaves it empty.
module bpu_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_addr,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] stack_q [DEPTH];
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   top_ptr;
    logic [CW-1:0]   cnt_q;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] wrap_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
    endfunction

    // ptr_q is the next free slot; the top sits just below it
    assign top_ptr = wrap_dec(ptr_q);
    assign top     = stack_q[top_ptr];
    assign empty   = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push) begin
            ptr_q <= wrap_inc(ptr_q);
            if (cnt_q != CW'(DEPTH)) cnt_q <= cnt_q + 1'b1;
        end else if (pop && !empty) begin
            ptr_q <= top_ptr;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) stack_q[ptr_q] <= push_addr;
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped tagged BTB with saturating counters; resolves in EX.
// Define BPU_RAS_EN to add the return-address stack for RET entries.
module branch_predictor_btb
    import bpu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 1024,
    parameter int TAG_BITS  = 8,
    parameter int CTR_BITS  = 2,
    parameter int RAS_DEPTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_predictor_btb_if.slave bp
);

    localparam int IDX = $clog2(ENTRIES);

    localparam logic [CTR_BITS-1:0] CTR_INIT  = CTR_BITS'(ctr_init(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_ALLOC = CTR_BITS'(ctr_alloc(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX   = CTR_BITS'(ctr_max(CTR_BITS));

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        btb_type_t           typ;
        logic [XLEN-1:0]     target;
        logic [CTR_BITS-1:0] ctr;
    } btb_entry_t;

    logic                valid_q [ENTRIES];
    logic [TAG_BITS-1:0] tag_q   [ENTRIES];
    btb_type_t           type_q  [ENTRIES];
    logic [XLEN-1:0]     tgt_q   [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q   [ENTRIES];

    logic [IDX-1:0]      f_idx;
    logic [IDX-1:0]      e_idx;
    logic [TAG_BITS-1:0] f_tag;
    logic [TAG_BITS-1:0] e_tag;
    logic                f_hit;
    logic                e_hit;
    btb_type_t           f_type;
    btb_type_t           e_type;
    logic [CTR_BITS-1:0] e_ctr;
    logic [CTR_BITS-1:0] ctr_upd;

    logic resolve;
    logic actual_taken;
    logic mispredict;
    logic is_ret;
    logic do_alloc;
    logic do_upd;

    btb_entry_t  wr_ent;
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    assign f_idx = IDX'(bpu_index(64'(bp.pc_F), IDX));
    assign e_idx = IDX'(bpu_index(64'(bp.pc_E), IDX));
    assign f_tag = TAG_BITS'(bpu_tag(64'(bp.pc_F), IDX, TAG_BITS));
    assign e_tag = TAG_BITS'(bpu_tag(64'(bp.pc_E), IDX, TAG_BITS));

    assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_type = type_q[f_idx];
    assign e_hit  = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign e_ctr  = ctr_q[e_idx];

    assign bp.taken_F = f_hit && ((f_type != COND) || ctr_q[f_idx][CTR_BITS-1]);
    assign bp.pc_next = bp.taken_F ? bp.pred_target_F : bp.pc4_F;

`ifdef BPU_RAS_EN
    logic            is_call;
    logic            ras_empty;
    logic [XLEN-1:0] ras_top;

    assign is_call = resolve && (bp.jump_E != JUMP_NONE) && is_link(bp.rd_E);
    assign is_ret  = (bp.jump_E == JUMP_JALR) && is_link(bp.rs1_E) &&
                     !is_link(bp.rd_E);

    bpu_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (is_call),
        .pop       (resolve && is_ret),
        .push_addr (bp.pc4_E),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    assign bp.pred_target_F = (f_hit && (f_type == RET) && !ras_empty) ?
                              ras_top : tgt_q[f_idx];
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_regs;

    assign unused_regs      = ^{bp.rd_E, bp.rs1_E};
    assign is_ret           = 1'b0;
    assign bp.pred_target_F = tgt_q[f_idx];
`endif

    assign resolve      = bp.valid_E && (bp.branch_E || (bp.jump_E != JUMP_NONE));
    assign actual_taken = bp.branch_E ? bp.cond_E : 1'b1;
    assign mispredict   = (actual_taken != bp.taken_E) ||
                          (actual_taken && bp.taken_E &&
                           (bp.pred_target_E != bp.pc_target_E));

    assign bp.flush      = resolve && mispredict;
    assign bp.pc_restore = (resolve && actual_taken) ? bp.pc_target_E : bp.pc4_E;

    always_comb begin
        e_type = COND;
        unique case (1'b1)
            bp.branch_E:
                e_type = COND;
            !bp.branch_E && is_ret:
                e_type = RET;
            !bp.branch_E && !is_ret && (bp.jump_E == JUMP_JALR):
                e_type = JALR;
            !bp.branch_E && (bp.jump_E == JUMP_JAL):
                e_type = JAL;
            default:
                e_type = COND;
        endcase
    end

    always_comb begin
        ctr_upd = e_ctr;
        if (actual_taken) begin
            if (e_ctr != CTR_MAX) ctr_upd = e_ctr + 1'b1;
        end else if (e_ctr != '0) begin
            ctr_upd = e_ctr - 1'b1;
        end
    end

    assign do_upd   = resolve && e_hit;
    assign do_alloc = resolve && !e_hit && actual_taken;

    always_comb begin
        wr_ent.valid  = 1'b1;
        wr_ent.tag    = e_tag;
        wr_ent.typ    = e_type;
        wr_ent.target = bp.pc_target_E;
        wr_ent.ctr    = e_hit ? ctr_upd : CTR_ALLOC;
    end

    // lookups read these arrays combinationally, so a same-cycle
    // update is only visible from the next cycle on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
            end
        end else if (do_alloc || do_upd) begin
            valid_q[e_idx] <= wr_ent.valid;
            ctr_q[e_idx]   <= wr_ent.ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) begin
            tag_q[e_idx]  <= wr_ent.tag;
            type_q[e_idx] <= wr_ent.typ;
            tgt_q[e_idx]  <= wr_ent.target;
        end else if (do_upd && actual_taken) begin
            tgt_q[e_idx]  <= wr_ent.target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (resolve)  stat_br_q <= stat_br_q + 32'd1;
            if (bp.flush) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign bp.stat_branches = stat_br_q;
    assign bp.stat_mispred  = stat_mp_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: table of resolve/lookup vectors
// plus sequences for write-after-read, RAS wrap and reset.
module tb_branch_predictor_btb;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    branch_predictor_btb_if #(.XLEN(32)) bus ();

    branch_predictor_btb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v;
        logic        br;
        logic [1:0]  jmp;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic        cond;
        logic        tk;
        logic [31:0] pred;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        e_flush;
        logic [31:0] e_rst;
        logic [31:0] lk_pc;
        logic        e_tkf;
        logic [31:0] e_tgt;
        logic        chk_ctr;
        logic [1:0]  e_ctr;
    } vec_t;

    localparam int NV = 18;
    vec_t tv [NV];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic ex_drive(input logic v, input logic br, input logic [1:0] jmp,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic cond, input logic tk,
                            input logic [31:0] pred, input logic [31:0] pc,
                            input logic [31:0] tgt);
        bus.valid_E       = v;
        bus.branch_E      = br;
        bus.jump_E        = jmp;
        bus.rd_E          = rd;
        bus.rs1_E         = rs1;
        bus.cond_E        = cond;
        bus.taken_E       = tk;
        bus.pred_target_E = pred;
        bus.pc_E          = pc;
        bus.pc4_E         = pc + 32'd4;
        bus.pc_target_E   = tgt;
    endtask

    task automatic ex_clear();
        ex_drive(1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0,
                 32'h0, 32'h0, 32'h0);
    endtask

    task automatic set_pc(input logic [31:0] pc);
        bus.pc_F  = pc;
        bus.pc4_F = pc + 32'd4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ctr_idx;
        logic [31:0] exp_pc;

        //   v    br   jmp   rd    rs1   cond tk   pred       pc           tgt
        //   flush rst        lk_pc        tkF  tgt        cc   ctr
        tv[0]  = '{1'b1,1'b1,2'd0,5'd0,5'd0,1'b1,1'b0,32'h0,  32'h200,   32'h180,
                   1'b1,32'h180, 32'h200,   1'b1,32'h180,1'b1,2'd2};
        tv[1]  = '{1'b1,1'b1,2'd0,5'd0,5'd0,1'b1,1'b1,32'h180,32'h200,   32'h180,
                   1'b0,32'h180, 32'h200,   1'b1,32'h180,1'b1,2'd3};
        tv[2]  = tv[1];
        tv[3]  = tv[1];
        tv[4]  = '{1'b1,1'b1,2'd0,5'd0,5'd0,1'b0,1'b1,32'h180,32'h200,   32'h180,
                   1'b1,32'h204, 32'h200,   1'b1,32'h180,1'b1,2'd2};
        tv[5]  = '{1'b1,1'b1,2'd0,5'd0,5'd0,1'b0,1'b1,32'h180,32'h200,   32'h180,
                   1'b1,32'h204, 32'h200,   1'b0,32'h0,  1'b1,2'd1};
        tv[6]  = '{1'b1,1'b1,2'd0,5'd0,5'd0,1'b1,1'b1,32'h180,32'h200,   32'h1C0,
                   1'b1,32'h1C0, 32'h200,   1'b1,32'h1C0,1'b1,2'd2};
        tv[7]  = '{1'b0,1'b1,2'd0,5'd0,5'd0,1'b1,1'b0,32'h0,  32'h200,   32'h240,
                   1'b0,32'h204, 32'h200,   1'b1,32'h1C0,1'b1,2'd2};
        tv[8]  = '{1'b1,1'b1,2'd0,5'd0,5'd0,1'b0,1'b1,32'h1C0,32'h200,   32'h1C0,
                   1'b1,32'h204, 32'h200,   1'b0,32'h0,  1'b1,2'd1};
        tv[9]  = '{1'b1,1'b1,2'd0,5'd0,5'd0,1'b0,1'b0,32'h0,  32'h200,   32'h1C0,
                   1'b0,32'h204, 32'h200,   1'b0,32'h0,  1'b1,2'd0};
        tv[10] = tv[9];
        tv[11] = '{1'b1,1'b1,2'd0,5'd0,5'd0,1'b0,1'b0,32'h0,  32'h600,   32'h640,
                   1'b0,32'h604, 32'h600,   1'b0,32'h0,  1'b0,2'd0};
        tv[12] = '{1'b1,1'b0,2'd1,5'd0,5'd0,1'b0,1'b0,32'h0,  32'h400,   32'h480,
                   1'b1,32'h480, 32'h400,   1'b1,32'h480,1'b0,2'd0};
        tv[13] = '{1'b1,1'b0,2'd2,5'd0,5'd6,1'b0,1'b0,32'h0,  32'h404,   32'h700,
                   1'b1,32'h700, 32'h404,   1'b1,32'h700,1'b0,2'd0};
        tv[14] = '{1'b1,1'b0,2'd2,5'd0,5'd6,1'b0,1'b1,32'h700,32'h404,   32'h700,
                   1'b0,32'h700, 32'h404,   1'b1,32'h700,1'b0,2'd0};
        tv[15] = '{1'b0,1'b0,2'd0,5'd0,5'd0,1'b0,1'b0,32'h0,  32'h0,     32'h0,
                   1'b0,32'h4,   32'h100400,1'b1,32'h480,1'b0,2'd0};
        tv[16] = '{1'b0,1'b0,2'd0,5'd0,5'd0,1'b0,1'b0,32'h0,  32'h0,     32'h0,
                   1'b0,32'h4,   32'h1400,  1'b0,32'h0,  1'b0,2'd0};
        tv[17] = '{1'b1,1'b0,2'd2,5'd0,5'd6,1'b0,1'b1,32'h700,32'h100404,32'h780,
                   1'b1,32'h780, 32'h404,   1'b1,32'h780,1'b0,2'd0};

        rst_n = 1'b0;
        ex_clear();
        set_pc(32'h100);
        #1;
        chk("reset taken_F", bus.taken_F, 1'b0);
        chk("reset pc_next", bus.pc_next, 32'h104);
        chk("reset stat_branches", bus.stat_branches, 32'd0);
        chk("reset stat_mispred", bus.stat_mispred, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post-reset pc_next", bus.pc_next, 32'h104);

        for (int i = 0; i < NV; i++) begin
            ex_drive(tv[i].v, tv[i].br, tv[i].jmp, tv[i].rd, tv[i].rs1,
                     tv[i].cond, tv[i].tk, tv[i].pred, tv[i].pc, tv[i].tgt);
            set_pc(32'h0);
            #1;
            chk($sformatf("v%0d flush", i), bus.flush, tv[i].e_flush);
            chk($sformatf("v%0d pc_restore", i), bus.pc_restore, tv[i].e_rst);
            step();
            ex_clear();
            set_pc(tv[i].lk_pc);
            #1;
            exp_pc = tv[i].e_tkf ? tv[i].e_tgt : tv[i].lk_pc + 32'd4;
            chk($sformatf("v%0d taken_F", i), bus.taken_F, tv[i].e_tkf);
            chk($sformatf("v%0d pc_next", i), bus.pc_next, exp_pc);
            if (tv[i].e_tkf)
                chk($sformatf("v%0d pred_target_F", i), bus.pred_target_F, tv[i].e_tgt);
            if (tv[i].chk_ctr) begin
                ctr_idx = int'((tv[i].lk_pc >> 2) & 32'h3FF);
                chk($sformatf("v%0d ctr", i), dut.ctr_q[ctr_idx], tv[i].e_ctr);
            end
        end

        // lookup and allocation at the same index in one cycle
        set_pc(32'h600);
        ex_drive(1'b1, 1'b1, 2'd0, 5'd0, 5'd0, 1'b1, 1'b0,
                 32'h0, 32'h600, 32'h6C0);
        #1;
        chk("war same-cycle taken_F", bus.taken_F, 1'b0);
        chk("war flush", bus.flush, 1'b1);
        step();
        ex_clear();
        #1;
        chk("war next taken_F", bus.taken_F, 1'b1);
        chk("war next pc_next", bus.pc_next, 32'h6C0);
        chk("stat_branches", bus.stat_branches, 32'd16);
        chk("stat_mispred", bus.stat_mispred, 32'd9);

`ifdef BPU_RAS_EN
        ex_drive(1'b1, 1'b0, 2'd1, 5'd1, 5'd0, 1'b0, 1'b0, 32'h0, 32'h300, 32'h500);
        step();
        ex_drive(1'b1, 1'b0, 2'd2, 5'd0, 5'd1, 1'b0, 1'b0, 32'h0, 32'h500, 32'h304);
        #1;
        chk("ras first ret flush", bus.flush, 1'b1);
        chk("ras first ret restore", bus.pc_restore, 32'h304);
        step();
        ex_drive(1'b1, 1'b0, 2'd1, 5'd1, 5'd0, 1'b0, 1'b0, 32'h0, 32'h340, 32'h500);
        step();
        ex_clear();
        set_pc(32'h500);
        #1;
        chk("ras ret taken_F", bus.taken_F, 1'b1);
        chk("ras ret target", bus.pred_target_F, 32'h344);
        ex_drive(1'b1, 1'b0, 2'd2, 5'd0, 5'd1, 1'b0, 1'b1, 32'h344, 32'h500, 32'h344);
        step();
        for (int k = 0; k < 9; k++) begin
            ex_drive(1'b1, 1'b0, 2'd1, (k % 2 == 0) ? 5'd1 : 5'd5, 5'd0, 1'b0,
                     1'b0, 32'h0, 32'h1000 + 32'(16 * k), 32'h500);
            step();
        end
        for (int j = 0; j < 8; j++) begin
            ex_clear();
            set_pc(32'h500);
            exp_pc = 32'h1004 + 32'(16 * (8 - j));
            #1;
            chk($sformatf("ras pop%0d target", j), bus.pred_target_F, exp_pc);
            ex_drive(1'b1, 1'b0, 2'd2, 5'd0, 5'd1, 1'b0, 1'b1,
                     exp_pc, 32'h500, exp_pc);
            #1;
            chk($sformatf("ras pop%0d flush", j), bus.flush, 1'b0);
            step();
        end
        ex_clear();
        #1;
        chk("ras empty fallback", bus.pred_target_F, 32'h1014);
        ex_drive(1'b1, 1'b0, 2'd2, 5'd0, 5'd1, 1'b0, 1'b1, 32'h1014, 32'h500, 32'h1014);
        step();
        ex_drive(1'b1, 1'b0, 2'd1, 5'd1, 5'd0, 1'b0, 1'b0, 32'h0, 32'h2000, 32'h500);
        step();
        ex_clear();
        #1;
        chk("ras after underflow", bus.pred_target_F, 32'h2004);
`endif

        rst_n = 1'b0;
        set_pc(32'h200);
        #1;
        chk("rerst taken_F", bus.taken_F, 1'b0);
        chk("rerst pc_next", bus.pc_next, 32'h204);
        chk("rerst stat_branches", bus.stat_branches, 32'd0);
        chk("rerst stat_mispred", bus.stat_mispred, 32'd0);
        step();
        rst_n = 1'b1;
        set_pc(32'h404);
        #1;
        chk("rerst jal miss", bus.taken_F, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
